mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch requester (port I) and the load/store requester (port D).
- Round-robin arbitration; one outstanding transaction at a time.
- Drives the select of the 2:1 address/write-data mux in front of memory (sel=0 → I, sel=1 → D), registers the winning request, and routes the response back to its owner.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between fetch (I) and load/store (D),
// one transaction in flight, registered request payload and response routing.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [AW-1:0]   i_addr,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic [AW-1:0]   d_addr,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            sel,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t          state_q, state_d;
    logic            last_q, last_d, sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW/8-1:0] be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
    logic            irv_q, irv_d, drv_q, drv_d;
    logic            win, acc, done;
    always_comb begin
        // win=1 picks D; on a tie the port that was not served last wins
        win      = (i_valid & d_valid) ? ~last_q : d_valid;
        acc      = (state_q == IDLE) & (i_valid | d_valid);
        done     = (state_q == RESP) & mem_rvalid;
        i_ready  = acc & ~win;
        d_ready  = acc & win;
        state_d  = acc ? REQ : ((state_q == REQ) & mem_gnt) ? RESP : done ? IDLE : state_q;
        last_d   = acc ? win : last_q;
        sel_d    = acc ? win : sel_q;
        addr_d   = acc ? (win ? d_addr : i_addr) : addr_q;
        we_d     = acc ? (win & d_we) : we_q;
        be_d     = acc ? (win ? d_be : '1) : be_q;
        wdata_d  = acc ? (win ? d_wdata : '0) : wdata_q;
        irv_d    = done & ~sel_q;
        drv_d    = done & sel_q;
        irdata_d = irv_d ? mem_rdata : irdata_q;
        drdata_d = drv_d ? (we_q ? '0 : mem_rdata) : drdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            irv_q    <= 1'b0;
            drv_q    <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            irv_q    <= irv_d;
            drv_q    <= drv_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end
    assign sel       = sel_q;
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign i_rvalid  = irv_q;
    assign d_rvalid  = drv_q;
    assign i_rdata   = irdata_q;
    assign d_rdata   = drdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, cycle-exact checks of arbitration, latency, reset and response routing.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    logic            clk = 1'b0, rst = 1'b1;
    logic            i_valid = 1'b0, d_valid = 1'b0, d_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [AW-1:0]   i_addr = '0, d_addr = '0;
    logic [DW/8-1:0] d_be = '0;
    logic [DW-1:0]   d_wdata = '0, mem_rdata = '0;
    logic            i_ready, i_rvalid, d_ready, d_rvalid, sel, mem_req, mem_we;
    logic [DW-1:0]   i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0]   mem_addr;
    logic [DW/8-1:0] mem_be;
    int n_chk = 0, n_fail = 0, ip = 0, dp = 0, ip0 = 0, dp0 = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sel(sel), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_rvalid) ip++;
        if (d_rvalid) dp++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_req", mem_req, 0);
        chk("rst_sel", sel, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we_be", {mem_we, mem_be}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ready", {i_ready, d_ready}, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b0;
        step();

        // single fetch
        ip0 = ip; dp0 = dp;
        i_valid = 1'b1; i_addr = 'h100;
        #1;
        chk("f_iready", i_ready, 1);
        chk("f_dready", d_ready, 0);
        step();
        i_valid = 1'b0; i_addr = '0;
        chk("f_req", mem_req, 1);
        chk("f_addr", mem_addr, 'h100);
        chk("f_we", mem_we, 0);
        chk("f_be", mem_be, 'hF);
        chk("f_wdata", mem_wdata, 0);
        chk("f_sel", sel, 0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("f_req_off", mem_req, 0);
        step();
        chk("f_no_early_rv", i_rvalid, 0);
        mem_rvalid = 1'b1; mem_rdata = 'hDEADBEEF;
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("f_irvalid", i_rvalid, 1);
        chk("f_irdata", i_rdata, 'hDEADBEEF);
        chk("f_drvalid", d_rvalid, 0);
        step();
        chk("f_pulse_end", i_rvalid, 0);
        chk("f_irdata_hold", i_rdata, 'hDEADBEEF);
        chk("f_icount", ip - ip0, 1);
        chk("f_dcount", dp - dp0, 0);

        // store
        d_valid = 1'b1; d_we = 1'b1; d_addr = 'h2004; d_be = 'h3; d_wdata = 'h1234;
        #1;
        chk("s_dready", d_ready, 1);
        chk("s_iready", i_ready, 0);
        step();
        d_valid = 1'b0;
        chk("s_req", mem_req, 1);
        chk("s_addr", mem_addr, 'h2004);
        chk("s_we", mem_we, 1);
        chk("s_be", mem_be, 'h3);
        chk("s_wdata", mem_wdata, 'h1234);
        chk("s_sel", sel, 1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 'hFFFFFFFF;
        step();
        mem_rvalid = 1'b0;
        chk("s_drvalid", d_rvalid, 1);
        chk("s_drdata", d_rdata, 0);
        chk("s_irvalid", i_rvalid, 0);
        chk("s_irdata_hold", i_rdata, 'hDEADBEEF);

        // tie after reset: I, D, I, D
        rst = 1'b1;
        step();
        rst = 1'b0;
        d_we = 1'b0; d_addr = 'h44; d_be = 'hF; i_addr = 'h104;
        i_valid = 1'b1; d_valid = 1'b1;
        ip0 = ip; dp0 = dp;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_iready", i_ready, k % 2 == 0);
            chk("tie_dready", d_ready, k % 2 == 1);
            step();
            chk("tie_sel", sel, k % 2 == 1);
            chk("tie_addr", mem_addr, (k % 2 == 1) ? 'h44 : 'h104);
            mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = k;
            step();
            mem_rvalid = 1'b0;
            if (k == 3) begin
                i_valid = 1'b0; d_valid = 1'b0;
            end
            chk("tie_owner_rv", (k % 2 == 1) ? d_rvalid : i_rvalid, 1);
            chk("tie_other_rv", (k % 2 == 1) ? i_rvalid : d_rvalid, 0);
        end
        step();
        chk("tie_icount", ip - ip0, 2);
        chk("tie_dcount", dp - dp0, 2);
        chk("tie_idle", mem_req, 0);

        // grant stall
        i_valid = 1'b1; i_addr = 'h300;
        step();
        d_valid = 1'b1;
        ip0 = ip; dp0 = dp;
        for (int k = 0; k < 6; k++) begin
            chk("st_req", mem_req, 1);
            chk("st_addr", mem_addr, 'h300);
            chk("st_ready", {i_ready, d_ready}, 0);
            chk("st_rvalid", {i_rvalid, d_rvalid}, 0);
            if (k < 5) step();
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
        chk("st_resp_req", mem_req, 0);
        mem_rvalid = 1'b1; mem_rdata = 'hCAFE;
        step();
        mem_rvalid = 1'b0;
        chk("st_irvalid", i_rvalid, 1);
        chk("st_irdata", i_rdata, 'hCAFE);
        chk("st_counts", {ip - ip0, dp - dp0}, {32'd0, 32'd0});

        // reset mid-RESP
        d_valid = 1'b1; d_addr = 'h80;
        #1;
        chk("rr_dready", d_ready, 1);
        step();
        d_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rr_in_resp", mem_req, 0);
        rst = 1'b1;
        step();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 'h1111;
        ip0 = ip; dp0 = dp;
        chk("rr_sel", sel, 0);
        chk("rr_addr", mem_addr, 0);
        chk("rr_we_be", {mem_we, mem_be}, 0);
        chk("rr_wdata", mem_wdata, 0);
        chk("rr_req", mem_req, 0);
        chk("rr_rdata", {i_rdata, d_rdata}, 0);
        step();
        mem_rvalid = 1'b0;
        chk("rr_no_rvalid", {i_rvalid, d_rvalid}, 0);
        i_valid = 1'b1; i_addr = 'h200;
        #1;
        chk("rr_iready", i_ready, 1);
        step();
        i_valid = 1'b0;
        chk("rr_new_req", mem_req, 1);
        chk("rr_new_addr", mem_addr, 'h200);
        chk("rr_counts", {ip - ip0, dp - dp0}, {32'd0, 32'd0});

        // back-to-back: fetch accepted in the cycle the load response pulses
        rst = 1'b1;
        step();
        rst = 1'b0;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 'h40;
        step();
        d_valid = 1'b0; i_valid = 1'b1; i_addr = 'h500;
        #1;
        chk("bb_iready_req", i_ready, 0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 'hA5A5A5A5;
        #1;
        chk("bb_iready_resp", i_ready, 0);
        step();
        mem_rvalid = 1'b0;
        chk("bb_drvalid", d_rvalid, 1);
        chk("bb_drdata", d_rdata, 'hA5A5A5A5);
        chk("bb_iready", i_ready, 1);
        chk("bb_dready", d_ready, 0);
        step();
        i_valid = 1'b0;
        chk("bb_req", mem_req, 1);
        chk("bb_addr", mem_addr, 'h500);
        chk("bb_sel", sel, 0);
        chk("bb_we_be", {mem_we, mem_be}, 'hF);
        chk("bb_drv_end", d_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
